// File: rtl/gf2e_batch_inv_pkg.sv
// Shared constants, state encoding and lane helper for the batch GF(2^16) inverter.
package gf2e_batch_inv_pkg;

    localparam int unsigned W       = 16;
    localparam int unsigned LANES   = 9;
    localparam int unsigned M       = W * LANES;
    localparam int unsigned N_STEPS = 29;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_WAIT = 3'd2;
    localparam state_t ST_CAPT = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    // Lane k (0-based) of an MSB-first lane vector.
    function automatic logic [0:W-1] lane_get(input logic [0:M-1] v, input int unsigned k);
        lane_get = v[k*W +: W];
    endfunction

endpackage

// File: rtl/gf2e_batch_inv.sv
// Batch GF(2^16) inverter: a^(2^16-2) per lane via a square/multiply chain
// driven through an external 9-lane multiplier array.
module gf2e_batch_inv
    import gf2e_batch_inv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_b,
    input  logic        start,
    input  logic [0:143] din,
    output logic [0:143] inv_r_dat,
    output logic        inv_done,
    output logic        busy,
    output logic [0:8]  zero_flag,
    output logic [0:15] mul1_o_out,
    output logic [0:15] mul2_o_out,
    output logic [0:15] mul3_o_out,
    output logic [0:15] mul4_o_out,
    output logic [0:15] mul5_o_out,
    output logic [0:15] mul6_o_out,
    output logic [0:15] mul7_o_out,
    output logic [0:15] mul8_o_out,
    output logic [0:15] mul9_o_out,
    output logic [0:15] mul1_t_out,
    output logic [0:15] mul2_t_out,
    output logic [0:15] mul3_t_out,
    output logic [0:15] mul4_t_out,
    output logic [0:15] mul5_t_out,
    output logic [0:15] mul6_t_out,
    output logic [0:15] mul7_t_out,
    output logic [0:15] mul8_t_out,
    output logic [0:15] mul9_t_out,
    input  logic [0:15] mul1_r_dat,
    input  logic [0:15] mul2_r_dat,
    input  logic [0:15] mul3_r_dat,
    input  logic [0:15] mul4_r_dat,
    input  logic [0:15] mul5_r_dat,
    input  logic [0:15] mul6_r_dat,
    input  logic [0:15] mul7_r_dat,
    input  logic [0:15] mul8_r_dat,
    input  logic [0:15] mul9_r_dat
);

    localparam logic [4:0] LAST_STEP = 5'(N_STEPS - 1);

    state_t           state_q, state_d;
    logic [4:0]       step_q, step_d;
    logic [0:M-1]     a_q, a_d;
    logic [0:M-1]     r_q, r_d;
    logic [0:M-1]     res_q, res_d;
    logic [0:M-1]     op_o_q, op_o_d;
    logic [0:M-1]     op_t_q, op_t_d;
    logic [0:LANES-1] zf_q, zf_d;
    logic             done_q, done_d;

    logic [0:M-1]     prod;
    logic [0:M-1]     t_sel;
    logic [0:LANES-1] din_zero;

    assign prod = {mul1_r_dat, mul2_r_dat, mul3_r_dat, mul4_r_dat, mul5_r_dat,
                   mul6_r_dat, mul7_r_dat, mul8_r_dat, mul9_r_dat};

    // Per-lane zero detect on the incoming vector and second-operand select
    // (even step squares r, odd step multiplies r by the latched operand).
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign din_zero[k]       = (lane_get(din, k) == '0);
        assign t_sel[k*W +: W]   = step_q[0] ? lane_get(a_q, k) : lane_get(r_q, k);
    end

    // Next-state logic for the step sequencer and datapath registers.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        r_d     = r_q;
        res_d   = res_q;
        op_o_d  = op_o_q;
        op_t_d  = op_t_q;
        zf_d    = zf_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = din;
                    r_d     = din;
                    zf_d    = din_zero;
                    step_d  = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                op_o_d  = r_q;
                op_t_d  = t_sel;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                r_d = prod;
                if (step_q == LAST_STEP) begin
                    res_d   = prod;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    step_d  = step_q + 5'd1;
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            a_q     <= '0;
            r_q     <= '0;
            res_q   <= '0;
            op_o_q  <= '0;
            op_t_q  <= '0;
            zf_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            r_q     <= r_d;
            res_q   <= res_d;
            op_o_q  <= op_o_d;
            op_t_q  <= op_t_d;
            zf_q    <= zf_d;
            done_q  <= done_d;
        end
    end

    assign inv_r_dat = res_q;
    assign inv_done  = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign zero_flag = zf_q;

    assign mul1_o_out = op_o_q[0:15];
    assign mul2_o_out = op_o_q[16:31];
    assign mul3_o_out = op_o_q[32:47];
    assign mul4_o_out = op_o_q[48:63];
    assign mul5_o_out = op_o_q[64:79];
    assign mul6_o_out = op_o_q[80:95];
    assign mul7_o_out = op_o_q[96:111];
    assign mul8_o_out = op_o_q[112:127];
    assign mul9_o_out = op_o_q[128:143];

    assign mul1_t_out = op_t_q[0:15];
    assign mul2_t_out = op_t_q[16:31];
    assign mul3_t_out = op_t_q[32:47];
    assign mul4_t_out = op_t_q[48:63];
    assign mul5_t_out = op_t_q[64:79];
    assign mul6_t_out = op_t_q[80:95];
    assign mul7_t_out = op_t_q[96:111];
    assign mul8_t_out = op_t_q[112:127];
    assign mul9_t_out = op_t_q[128:143];

endmodule
